pm_dllp_tracker: RTL and testbench

Parametrised multi-slot PCIe power-management DLLP receiver for the data link layer. Decodes up to NUM_SLOTS DLLP first-bytes per cycle into PM types using the team's PM encoding. Tracks the local PM_Enter handshake (request → PM_Request_Ack, with timeout) and counts reserved encodings. Sits between the DLLP receive parser and the LTSSM / link power controller.

---
 rtl/pcie_pm_pkg.sv | 30 +++
 rtl/pm_dllp_slot_decode.sv | 34 +++
 rtl/pm_dllp_tracker.sv | 169 ++++++++++++++++
 tb/tb_pm_dllp_tracker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pm_pkg.sv
// Shared PCIe power-management DLLP definitions: byte-0 prefix, raw low-bit
// codes, the decoded PM type encoding and the PM_Enter handshake FSM states.
package pcie_pm_pkg;

   // Byte0[7:3] of every PM DLLP
   localparam logic [4:0] PM_PREFIX = 5'b00100;

   // Raw byte0[2:0] codes within the PM prefix
   localparam logic [2:0] RAW_ENTER_L1  = 3'b000;
   localparam logic [2:0] RAW_ENTER_L23 = 3'b001;
   localparam logic [2:0] RAW_ASPM_L1   = 3'b010;
   localparam logic [2:0] RAW_REQ_ACK   = 3'b100;

   // Decoded PM type presented to the link power controller
   typedef enum logic [2:0] {
      ENTER_L1  = 3'b000,
      ENTER_L23 = 3'b001,
      ASPM_L1   = 3'b010,
      REQ_ACK   = 3'b011,
      RSVD      = 3'b111
   } pm_type_t;

   // Local PM_Enter handshake states
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_ACK = 2'b01,
      DONE     = 2'b10
   } pm_state_t;

endpackage

// File: rtl/pm_dllp_slot_decode.sv
// Combinational decode of one DLLP slot: accepted PM DLLP type, or flag a
// PM-prefixed DLLP whose low bits are a reserved encoding.
module pm_dllp_slot_decode
   import pcie_pm_pkg::*;
(
   input  logic [7:0] byte0,
   input  logic       valid,
   input  logic       crc_ok,
   output logic       is_pm,
   output pm_type_t   pm_type,
   output logic       is_rsvd
);

   logic     accepted;
   logic     prefix_hit;
   pm_type_t raw_type;

   // Map the low bits to a PM type and qualify with acceptance and prefix
   always_comb begin
      accepted   = valid & crc_ok;
      prefix_hit = (byte0[7:3] == PM_PREFIX);
      case (byte0[2:0])
         RAW_ENTER_L1:  raw_type = ENTER_L1;
         RAW_ENTER_L23: raw_type = ENTER_L23;
         RAW_ASPM_L1:   raw_type = ASPM_L1;
         RAW_REQ_ACK:   raw_type = REQ_ACK;
         default:       raw_type = RSVD;
      endcase
      is_pm   = accepted & prefix_hit & (raw_type != RSVD);
      is_rsvd = accepted & prefix_hit & (raw_type == RSVD);
      pm_type = is_pm ? raw_type : RSVD;
   end

endmodule

// File: rtl/pm_dllp_tracker.sv
// Multi-slot PM DLLP receiver: registered per-slot decode, saturating count of
// reserved PM encodings, and the local PM_Enter -> PM_Request_Ack handshake
// tracker with timeout.
module pm_dllp_tracker
   import pcie_pm_pkg::*;
#(
   parameter int NUM_SLOTS   = 2,
   parameter int ACK_TIMEOUT = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SLOTS-1:0]   dllp_valid,
   input  logic [NUM_SLOTS*8-1:0] dllp_byte0,
   input  logic [NUM_SLOTS-1:0]   dllp_crc_ok,
   output logic [NUM_SLOTS-1:0]   pm_valid,
   output logic [NUM_SLOTS*3-1:0] pm_type,
   output logic                   rx_enter_req,
   input  logic                   tx_req,
   output logic                   tx_busy,
   output logic                   tx_ack_done,
   output logic                   tx_timeout,
   input  logic                   cnt_clr,
   output logic [CNT_W-1:0]       rsv_cnt
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam int SUM_W = $clog2(NUM_SLOTS + 1);
   localparam int ACC_W = CNT_W + SUM_W;
   localparam logic [ACC_W-1:0] CNT_MAX = ACC_W'({CNT_W{1'b1}});

   logic [NUM_SLOTS-1:0]   slot_pm;
   logic [NUM_SLOTS-1:0]   slot_rsvd;
   logic [NUM_SLOTS-1:0]   slot_enter;
   logic [NUM_SLOTS-1:0]   slot_ack;
   pm_type_t               slot_type [NUM_SLOTS];

   logic [NUM_SLOTS*3-1:0] pm_type_next;
   logic [SUM_W-1:0]       rsvd_inc;
   logic [ACC_W-1:0]       rsv_sum;

   logic [NUM_SLOTS-1:0]   pm_valid_reg;
   logic [NUM_SLOTS*3-1:0] pm_type_reg;
   logic                   rx_enter_req_reg;
   logic [CNT_W-1:0]       rsv_cnt_reg;

   pm_state_t              state_reg, state_next;
   logic [TMR_W-1:0]       timer_reg, timer_next;
   logic                   ack_done_next, timeout_next;
   logic                   tx_busy_reg, tx_ack_done_reg, tx_timeout_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         pm_dllp_slot_decode u_dec (
            .byte0   (dllp_byte0[8*gi +: 8]),
            .valid   (dllp_valid[gi]),
            .crc_ok  (dllp_crc_ok[gi]),
            .is_pm   (slot_pm[gi]),
            .pm_type (slot_type[gi]),
            .is_rsvd (slot_rsvd[gi])
         );
         assign slot_ack[gi]   = slot_pm[gi] & (slot_type[gi] == REQ_ACK);
         assign slot_enter[gi] = slot_pm[gi] & ((slot_type[gi] == ENTER_L1) |
                                                (slot_type[gi] == ENTER_L23) |
                                                (slot_type[gi] == ASPM_L1));
      end
   endgenerate

   // Pack per-slot types and count reserved PM encodings seen this cycle
   always_comb begin
      pm_type_next = '0;
      rsvd_inc     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         pm_type_next[3*i +: 3] = slot_type[i];
         rsvd_inc               = rsvd_inc + SUM_W'(slot_rsvd[i]);
      end
   end

   assign rsv_sum = ACC_W'(rsv_cnt_reg) + ACC_W'(rsvd_inc);

   // Register the decode results (one cycle latency)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_valid_reg     <= '0;
         pm_type_reg      <= {NUM_SLOTS{3'b111}};
         rx_enter_req_reg <= 1'b0;
      end else begin
         pm_valid_reg     <= slot_pm;
         pm_type_reg      <= pm_type_next;
         rx_enter_req_reg <= |slot_enter;
      end
   end

   // Saturating reserved-encoding counter; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsv_cnt_reg <= '0;
      end else if (cnt_clr) begin
         rsv_cnt_reg <= '0;
      end else if (rsv_sum > CNT_MAX) begin
         rsv_cnt_reg <= {CNT_W{1'b1}};
      end else begin
         rsv_cnt_reg <= rsv_sum[CNT_W-1:0];
      end
   end

   // Handshake next state: ack beats timeout beats abort
   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      ack_done_next = 1'b0;
      timeout_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tx_req) begin
               state_next = WAIT_ACK;
               timer_next = '0;
            end
         end
         WAIT_ACK: begin
            if (|slot_ack) begin
               state_next    = DONE;
               ack_done_next = 1'b1;
            end else if (timer_reg == TMR_LAST) begin
               state_next   = DONE;
               timeout_next = 1'b1;
            end else if (!tx_req) begin
               state_next = IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         DONE: begin
            if (!tx_req) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake state, timer and registered status/pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         timer_reg       <= '0;
         tx_busy_reg     <= 1'b0;
         tx_ack_done_reg <= 1'b0;
         tx_timeout_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         timer_reg       <= timer_next;
         tx_busy_reg     <= (state_next == WAIT_ACK);
         tx_ack_done_reg <= ack_done_next;
         tx_timeout_reg  <= timeout_next;
      end
   end

   assign pm_valid     = pm_valid_reg;
   assign pm_type      = pm_type_reg;
   assign rx_enter_req = rx_enter_req_reg;
   assign rsv_cnt      = rsv_cnt_reg;
   assign tx_busy      = tx_busy_reg;
   assign tx_ack_done  = tx_ack_done_reg;
   assign tx_timeout   = tx_timeout_reg;

endmodule

// File: tb/tb_pm_dllp_tracker.sv
// Directed bench for pm_dllp_tracker: a decode/counter vector table followed by
// hand-written handshake, timeout, abort and reset sequences.
module tb_pm_dllp_tracker;

   localparam int NS = 2;
   localparam int TO = 16;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] dllp_valid;
   logic [NS*8-1:0] dllp_byte0;
   logic [NS-1:0] dllp_crc_ok;
   logic [NS-1:0] pm_valid;
   logic [NS*3-1:0] pm_type;
   logic          rx_enter_req;
   logic          tx_req;
   logic          tx_busy;
   logic          tx_ack_done;
   logic          tx_timeout;
   logic          cnt_clr;
   logic [CW-1:0] rsv_cnt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pm_dllp_tracker #(
      .NUM_SLOTS   (NS),
      .ACK_TIMEOUT (TO),
      .CNT_W       (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dllp_valid   (dllp_valid),
      .dllp_byte0   (dllp_byte0),
      .dllp_crc_ok  (dllp_crc_ok),
      .pm_valid     (pm_valid),
      .pm_type      (pm_type),
      .rx_enter_req (rx_enter_req),
      .tx_req       (tx_req),
      .tx_busy      (tx_busy),
      .tx_ack_done  (tx_ack_done),
      .tx_timeout   (tx_timeout),
      .cnt_clr      (cnt_clr),
      .rsv_cnt      (rsv_cnt)
   );

   typedef struct {
      logic [1:0]  v;
      logic [15:0] b0;
      logic [1:0]  crc;
      logic        clr;
      logic [1:0]  e_pv;
      logic [5:0]  e_pt;
      logic        e_enter;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [15:0] b, input logic [1:0] c);
      dllp_valid  = v;
      dllp_byte0  = b;
      dllp_crc_ok = c;
   endtask

   // {tx_busy, tx_ack_done, tx_timeout}
   task automatic chk_tx(input string name, input logic [2:0] exp);
      chk(name, {29'd0, tx_busy, tx_ack_done, tx_timeout}, {29'd0, exp});
   endtask

   initial begin
      // slot1 is the upper byte / upper type field in every entry
      vecs[0]  = '{2'b11, 16'h2420, 2'b11, 1'b0, 2'b11, 6'b011_000, 1'b1, 2'd0};
      vecs[1]  = '{2'b11, 16'h2723, 2'b01, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd1};
      vecs[2]  = '{2'b11, 16'h2221, 2'b11, 1'b0, 2'b11, 6'b010_001, 1'b1, 2'd1};
      vecs[3]  = '{2'b01, 16'h2024, 2'b11, 1'b0, 2'b01, 6'b111_011, 1'b0, 2'd1};
      vecs[4]  = '{2'b11, 16'h0040, 2'b11, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd1};
      vecs[5]  = '{2'b11, 16'h2526, 2'b11, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd3};
      vecs[6]  = '{2'b01, 16'h0027, 2'b01, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd3};
      vecs[7]  = '{2'b01, 16'h0023, 2'b01, 1'b1, 2'b00, 6'b111_111, 1'b0, 2'd0};
      vecs[8]  = '{2'b11, 16'h2F23, 2'b11, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd1};
      vecs[9]  = '{2'b10, 16'h2300, 2'b10, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd2};
      vecs[10] = '{2'b11, 16'h2422, 2'b01, 1'b0, 2'b01, 6'b111_010, 1'b1, 2'd2};
      vecs[11] = '{2'b00, 16'h2020, 2'b11, 1'b0, 2'b00, 6'b111_111, 1'b0, 2'd2};

      rst_n   = 1'b0;
      tx_req  = 1'b0;
      cnt_clr = 1'b0;
      drive(2'b00, 16'h0000, 2'b00);
      step;
      step;
      chk("rst_pm_valid", {30'd0, pm_valid}, 32'd0);
      chk("rst_pm_type", {26'd0, pm_type}, 32'h3F);
      chk("rst_enter", {31'd0, rx_enter_req}, 32'd0);
      chk("rst_cnt", {30'd0, rsv_cnt}, 32'd0);
      chk_tx("rst_tx", 3'b000);
      rst_n = 1'b1;
      step;

      // Decode / counter table, FSM left idle (stray Ack in entry 3)
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].v, vecs[i].b0, vecs[i].crc);
         cnt_clr = vecs[i].clr;
         step;
         $display("vec %0d: valid=%b byte0=%h crc=%b clr=%b -> pm_valid=%b pm_type=%b enter=%b cnt=%0d",
                  i, vecs[i].v, vecs[i].b0, vecs[i].crc, vecs[i].clr, pm_valid, pm_type, rx_enter_req, rsv_cnt);
         chk($sformatf("vec%0d_pm_valid", i), {30'd0, pm_valid}, {30'd0, vecs[i].e_pv});
         chk($sformatf("vec%0d_pm_type", i), {26'd0, pm_type}, {26'd0, vecs[i].e_pt});
         chk($sformatf("vec%0d_enter", i), {31'd0, rx_enter_req}, {31'd0, vecs[i].e_enter});
         chk($sformatf("vec%0d_cnt", i), {30'd0, rsv_cnt}, {30'd0, vecs[i].e_cnt});
         chk_tx($sformatf("vec%0d_tx_idle", i), 3'b000);
      end

      // Saturation over 5 reserved cycles, then clear concurrent with increment
      drive(2'b00, 16'h0000, 2'b00);
      cnt_clr = 1'b1;
      step;
      chk("sat_clear", {30'd0, rsv_cnt}, 32'd0);
      cnt_clr = 1'b0;
      drive(2'b01, 16'h0023, 2'b01);
      for (int k = 1; k <= 5; k++) begin
         step;
         $display("sat cycle %0d: rsv_cnt=%0d", k, rsv_cnt);
         chk($sformatf("sat_cnt_%0d", k), {30'd0, rsv_cnt}, (k < 3) ? k : 3);
      end
      cnt_clr = 1'b1;
      step;
      chk("sat_clr_priority", {30'd0, rsv_cnt}, 32'd0);
      cnt_clr = 1'b0;
      drive(2'b00, 16'h0000, 2'b00);

      // Handshake: Ack in slot1 after 5 cycles in WAIT_ACK
      tx_req = 1'b1;
      step;
      chk_tx("hs_enter", 3'b100);
      for (int k = 0; k < 4; k++) begin
         step;
         chk_tx($sformatf("hs_wait_%0d", k), 3'b100);
      end
      drive(2'b10, 16'h2400, 2'b10);
      step;
      $display("hs ack: busy=%b ack_done=%b timeout=%b pm_valid=%b", tx_busy, tx_ack_done, tx_timeout, pm_valid);
      chk_tx("hs_ack_pulse", 3'b010);
      chk("hs_ack_pm_valid", {30'd0, pm_valid}, 32'h2);
      chk("hs_ack_pm_type", {26'd0, pm_type}, 32'b011_111);
      drive(2'b00, 16'h0000, 2'b00);
      for (int k = 0; k < 4; k++) begin
         step;
         chk_tx($sformatf("hs_done_hold_%0d", k), 3'b000);
      end
      tx_req = 1'b0;
      step;
      chk_tx("hs_release", 3'b000);
      tx_req = 1'b1;
      step;
      chk_tx("hs_rearm", 3'b100);
      tx_req = 1'b0;
      step;
      chk_tx("hs_rearm_abort", 3'b000);

      // Timeout: pulse exactly TO cycles after WAIT_ACK entry
      tx_req = 1'b1;
      step;
      chk_tx("to_enter", 3'b100);
      for (int k = 1; k <= TO; k++) begin
         step;
         chk_tx($sformatf("to_cycle_%0d", k), (k == TO) ? 3'b001 : 3'b100);
      end
      $display("timeout pulse observed state: busy=%b timeout=%b", tx_busy, tx_timeout);
      step;
      chk_tx("to_single_pulse", 3'b000);
      tx_req = 1'b0;
      step;

      // Ack on the final timer cycle wins over timeout
      tx_req = 1'b1;
      step;
      for (int k = 1; k < TO; k++) begin
         step;
         chk_tx($sformatf("lastack_wait_%0d", k), 3'b100);
      end
      drive(2'b01, 16'h0024, 2'b01);
      step;
      $display("last-cycle ack: ack_done=%b timeout=%b", tx_ack_done, tx_timeout);
      chk_tx("lastack_pulse", 3'b010);
      drive(2'b00, 16'h0000, 2'b00);
      step;
      chk_tx("lastack_no_timeout", 3'b000);
      tx_req = 1'b0;
      step;

      // Abort: drop tx_req in WAIT_ACK, no pulse ever follows
      tx_req = 1'b1;
      step;
      chk_tx("abort_enter", 3'b100);
      step;
      step;
      tx_req = 1'b0;
      step;
      chk_tx("abort_idle", 3'b000);
      for (int k = 0; k < TO + 4; k++) begin
         step;
         chk_tx($sformatf("abort_quiet_%0d", k), 3'b000);
      end

      // Asynchronous reset in the middle of WAIT_ACK
      tx_req = 1'b1;
      step;
      step;
      drive(2'b11, 16'h2320, 2'b11);
      step;
      chk("prerst_pm_valid", {30'd0, pm_valid}, 32'h1);
      chk("prerst_enter", {31'd0, rx_enter_req}, 32'd1);
      chk("prerst_cnt", {30'd0, rsv_cnt}, 32'd1);
      chk_tx("prerst_busy", 3'b100);
      #3;
      rst_n = 1'b0;
      #1;
      $display("mid-wait reset: pm_valid=%b pm_type=%b busy=%b cnt=%0d", pm_valid, pm_type, tx_busy, rsv_cnt);
      chk("midrst_pm_valid", {30'd0, pm_valid}, 32'd0);
      chk("midrst_pm_type", {26'd0, pm_type}, 32'h3F);
      chk("midrst_enter", {31'd0, rx_enter_req}, 32'd0);
      chk("midrst_cnt", {30'd0, rsv_cnt}, 32'd0);
      chk_tx("midrst_tx", 3'b000);
      tx_req = 1'b0;
      drive(2'b00, 16'h0000, 2'b00);
      step;
      rst_n = 1'b1;
      for (int k = 0; k < TO + 2; k++) begin
         step;
         chk_tx($sformatf("postrst_quiet_%0d", k), 3'b000);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
